fifo_top_in: RTL and testbench

Bus-mapped 8-entry x 32-bit input FIFO for the factorial machine's operand path. A host writes operands through a push register and reads them back through a pop register, both gated by a slave select. Occupancy count and a 6-bit status/handshake flag vector are exported for the bus status mux and for interrupt logic.

---
 rtl/fifo_top_in_pkg.sv | 37 +++
 rtl/fifo_core.sv | 61 ++++++
 rtl/fifo_top_in.sv | 57 +++++
 tb/tb_fifo_top_in.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_top_in_pkg.sv
// Shared constants and types for the factorial-machine operand input FIFO.
// Optional feature macro: FIFO_CLEAR_EN (write to ADDR_CLR flushes the FIFO).
package fifo_top_in_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [7:0] ADDR_POP  = 8'h10;
  localparam logic [7:0] ADDR_PUSH = 8'h11;
  localparam logic [7:0] ADDR_CLR  = 8'h12;

  localparam int FLG_FULL   = 0;
  localparam int FLG_EMPTY  = 1;
  localparam int FLG_WR_ACK = 2;
  localparam int FLG_WR_ERR = 3;
  localparam int FLG_RD_ACK = 4;
  localparam int FLG_RD_ERR = 5;
  localparam int FLG_W      = 6;

  // Packed so that member order matches the exported flag bit indices.
  typedef struct packed {
    logic rd_err;
    logic rd_ack;
    logic wr_err;
    logic wr_ack;
    logic empty;
    logic full;
  } fifo_flag_t;

  // Decoded single-cycle bus access towards the core.
  typedef struct packed {
    logic push;
    logic pop;
    logic clr;
  } fifo_req_t;
endpackage

// File: rtl/fifo_core.sv
// Circular buffer with head/tail/count and registered ack/err pulses.
module fifo_core
  import fifo_top_in_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  fifo_req_t         req,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output fifo_flag_t        flag
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             head, tail;
  logic                         full, empty;
  logic                         do_push, do_pop;
  logic                         wr_ack, wr_err, rd_ack, rd_err;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = req.push && !full;
  assign do_pop  = req.pop && !empty;
  assign rdata   = mem[head];

  // Storage array: written on accepted push only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

  // Pointers, occupancy and one-cycle handshake pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_ack <= do_push || req.clr;
      wr_err <= req.push && full;
      rd_ack <= do_pop;
      rd_err <= req.pop && empty;
      if (req.clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (do_push) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end else if (do_pop) begin
        head  <= head + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  assign flag = '{rd_err: rd_err, rd_ack: rd_ack, wr_err: wr_err,
                  wr_ack: wr_ack, empty: empty, full: full};
endmodule

// File: rtl/fifo_top_in.sv
// Bus-mapped 8x32 operand input FIFO: address decode and registered read mux.
// Optional feature macro: FIFO_CLEAR_EN maps a flush command at ADDR_CLR.
module fifo_top_in
  import fifo_top_in_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic              wr,
  input  logic [7:0]        address,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic [FLG_W-1:0]  fifo_flag
);
  fifo_req_t         req;
  fifo_flag_t        flag;
  logic [DATA_W-1:0] rdata;
  logic              stat_rd;
  logic [DATA_W-1:0] dout_nxt;

  assign req.push = sel && wr && (address == ADDR_PUSH);
  assign req.pop  = sel && !wr && (address == ADDR_POP);
`ifdef FIFO_CLEAR_EN
  assign req.clr  = sel && wr && (address == ADDR_CLR);
`else
  assign req.clr  = 1'b0;
`endif
  assign stat_rd  = sel && !wr && (address == ADDR_PUSH);

  fifo_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wdata   (din),
    .rdata   (rdata),
    .count   (fifo_cnt),
    .flag    (flag)
  );

  assign fifo_flag = flag;

  // Read data select: popped word, status snapshot, or zero for anything else.
  always_comb begin
    dout_nxt = '0;
    if (req.pop && !flag.empty)
      dout_nxt = rdata;
    else if (stat_rd)
      dout_nxt = {{(DATA_W-FLG_W-CNT_W){1'b0}}, fifo_flag, fifo_cnt};
  end

  // Registered read data, one-cycle latency after the sampling edge.
  always_ff @(posedge clk) begin
    if (!reset_n) dout <= '0;
    else          dout <= dout_nxt;
  end
endmodule

// File: tb/tb_fifo_top_in.sv
// Self-checking bench for fifo_top_in against a queue-based reference model.
module tb_fifo_top_in;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [3:0]  fifo_cnt;
  logic [5:0]  fifo_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] q[$];
  logic m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
  logic [31:0] e_dout;

  fifo_top_in dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .wr(wr), .address(address),
    .din(din), .dout(dout), .fifo_cnt(fifo_cnt), .fifo_flag(fifo_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] m_flag();
    return {m_rd_err, m_rd_ack, m_wr_err, m_wr_ack,
            (q.size() == 0), (q.size() == 8)};
  endfunction

  task automatic check_all(input string tag);
    logic [5:0] ef;
    logic [3:0] ec;
    ef = m_flag();
    ec = 4'(q.size());
    checks++;
    assert (dout === e_dout) else begin
      errors++;
      $error("FAIL %s dout: got %h want %h", tag, dout, e_dout);
    end
    checks++;
    assert (fifo_cnt === ec) else begin
      errors++;
      $error("FAIL %s fifo_cnt: got %0d want %0d", tag, fifo_cnt, ec);
    end
    checks++;
    assert (fifo_flag === ef) else begin
      errors++;
      $error("FAIL %s fifo_flag: got %b want %b", tag, fifo_flag, ef);
    end
  endtask

  // One bus cycle: drive at negedge, update model from pre-edge state, check after edge.
  task automatic access(input logic s, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input string tag);
    logic [5:0] pf;
    logic [3:0] pc;
    @(negedge clk);
    sel = s; wr = w; address = a; din = d;
    pf = m_flag();
    pc = 4'(q.size());
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
    e_dout = '0;
    if (s && w && a == 8'h11) begin
      if (q.size() < 8) begin q.push_back(d); m_wr_ack = 1; end
      else m_wr_err = 1;
    end else if (s && !w && a == 8'h10) begin
      if (q.size() > 0) begin e_dout = q.pop_front(); m_rd_ack = 1; end
      else m_rd_err = 1;
    end else if (s && !w && a == 8'h11) begin
      e_dout = {22'b0, pf, pc};
    end
`ifdef FIFO_CLEAR_EN
    else if (s && w && a == 8'h12) begin
      q.delete();
      m_wr_ack = 1;
    end
`endif
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 0; sel = $urandom_range(0, 1); wr = $urandom_range(0, 1);
    address = 8'h11; din = $urandom;
    q.delete();
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
    e_dout = '0;
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    reset_n = 1; sel = 0;
  endtask

  initial begin
    logic [7:0] ra;
    logic [31:0] wd;
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
    e_dout = '0;

    do_reset("reset");
    access(0, 0, 8'h00, 32'h0, "idle");
    checks++;
    assert (fifo_flag === 6'b000010 && fifo_cnt === 4'd0 && dout === 32'd0) else begin
      errors++;
      $error("FAIL idle_const: got flag %b cnt %0d dout %h want 000010 0 0",
             fifo_flag, fifo_cnt, dout);
    end

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      wd = 32'h1111_1111 * i;
      access(1, 1, 8'h11, wd, "push");
    end
    checks++;
    assert (fifo_flag[0] === 1'b1 && fifo_cnt === 4'd8) else begin
      errors++;
      $error("FAIL full_const: got flag %b cnt %0d want full cnt 8", fifo_flag, fifo_cnt);
    end
    access(1, 1, 8'h11, 32'h8888_8888, "overflow");
    checks++;
    assert (fifo_flag[3] === 1'b1) else begin
      errors++;
      $error("FAIL wr_err_const: got flag %b want bit3 set", fifo_flag);
    end

    // Drain with a held read, including underflow
    for (int i = 0; i < 9; i++) access(1, 0, 8'h10, 32'h0, "pop");
    checks++;
    assert (fifo_flag === 6'b100010 && dout === 32'd0) else begin
      errors++;
      $error("FAIL underflow_const: got flag %b dout %h want 100010 0", fifo_flag, dout);
    end

    // Write to pop address is ignored; push then status read
    access(1, 1, 8'h10, 32'h1111_1111, "wr_pop_addr");
    access(1, 1, 8'h11, 32'h1111_1111, "push1");
    access(1, 0, 8'h11, 32'h0, "status");
    checks++;
    assert (dout === 32'h0000_0041) else begin
      errors++;
      $error("FAIL status_const: got %h want 00000041", dout);
    end

    // Deselected traffic and unmapped read
    for (int i = 0; i < 6; i++)
      access(0, 1'(i), (i % 2) ? 8'h11 : 8'h10, $urandom, "nosel");
    access(1, 0, 8'h12, 32'h0, "rd_12");

    // Reset mid-stream
    for (int i = 0; i < 4; i++) access(1, 1, 8'h11, $urandom, "push5");
    do_reset("reset_mid");
    access(1, 0, 8'h10, 32'h0, "pop_after_reset");

`ifdef FIFO_CLEAR_EN
    for (int i = 0; i < 3; i++) access(1, 1, 8'h11, $urandom, "push3");
    access(1, 1, 8'h12, 32'h0, "clear");
    checks++;
    assert (fifo_cnt === 4'd0 && fifo_flag[2] === 1'b1) else begin
      errors++;
      $error("FAIL clear_const: got cnt %0d flag %b want 0 wr_ack", fifo_cnt, fifo_flag);
    end
`else
    access(1, 1, 8'h12, 32'h0, "wr_12");
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1: ra = 8'h11;
        2, 3: ra = 8'h10;
        4:    ra = 8'h12;
        default: ra = 8'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
      else access($urandom_range(0, 7) != 0, $urandom_range(0, 1), ra, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
